vga_sync: RTL and testbench

- Generates 640x480 @ 60 Hz VGA timing from the 100 MHz board clock.
- Produces the pixel coordinates x/y consumed by the digit, paddle and ball renderers, plus hsync/vsync for the connector.
- Also produces video_on for RGB blanking, a pixel-rate strobe, and a once-per-frame tick for game-state updates.
- Sits at the top of the display path; all renderers sample x/y on the same clock.

---
 rtl/vga_sync_if.sv | 19 +
 rtl/vga_sync.sv | 142 ++++++++++++++
 tb/tb_vga_sync.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// Output bundle of the VGA timing generator: pixel strobe, coordinates,
// sync pulses, blanking and the per-frame tick.
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_tick;

  modport master (
    output p_tick, x, y, hsync, vsync, video_on, frame_tick
  );

  modport slave (
    input p_tick, x, y, hsync, vsync, video_on, frame_tick
  );
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: divides the system clock down to the pixel rate,
// walks the pixel/line counters and derives registered sync, blanking and
// frame-tick outputs that line up with the x/y presented in the same cycle.
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [9:0] X_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Inclusive range test used for both sync windows.
  function automatic logic in_range(input logic [9:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  logic [DIV_W-1:0] r_div;
  logic             r_p_tick;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_frame_tick;
  logic             r_run;

  logic [DIV_W-1:0] w_div_next;
  logic             w_p_tick_next;
  logic [9:0]       w_x_next;
  logic [9:0]       w_y_next;
  logic             w_hsync_next;
  logic             w_vsync_next;
  logic             w_video_on_next;
  logic             w_frame_tick_next;
  logic             w_run_next;

  // Next-state counters and the outputs derived from those next values.
  always_comb begin
    w_div_next        = DIV_ZERO;
    w_x_next          = r_x;
    w_y_next          = r_y;
    w_p_tick_next     = 1'b0;
    w_run_next        = r_run;
    w_hsync_next      = 1'b1;
    w_vsync_next      = 1'b1;
    w_video_on_next   = 1'b0;
    w_frame_tick_next = 1'b0;

    if (r_div >= DIV_MAX) begin
      w_div_next = DIV_ZERO;
    end else begin
      w_div_next = r_div + DIV_ONE;
    end

    // Counters move only on the edge that closes a p_tick cycle; the >=
    // compares keep a corrupted counter from running past its total.
    if (r_p_tick) begin
      if (r_x >= X_MAX) begin
        w_x_next = 10'd0;
        if (r_y >= Y_MAX) begin
          w_y_next = 10'd0;
        end else begin
          w_y_next = r_y + 10'd1;
        end
      end else begin
        w_x_next = r_x + 10'd1;
        w_y_next = r_y;
      end
    end else begin
      w_x_next = r_x;
      w_y_next = r_y;
    end

    w_p_tick_next = (w_div_next == DIV_MAX);
    // Blanking is held until the first pixel strobe after reset.
    w_run_next        = r_run | w_p_tick_next;
    w_hsync_next      = ~in_range(w_x_next, HS_FIRST, HS_LAST);
    w_vsync_next      = ~in_range(w_y_next, VS_FIRST, VS_LAST);
    w_video_on_next   = w_run_next && (w_x_next < H_VIS) && (w_y_next < V_VIS);
    w_frame_tick_next = w_p_tick_next && (w_x_next == X_MAX) && (w_y_next == Y_MAX);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div        <= DIV_ZERO;
      r_p_tick     <= 1'b0;
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
      r_video_on   <= 1'b0;
      r_frame_tick <= 1'b0;
      r_run        <= 1'b0;
    end else begin
      r_div        <= w_div_next;
      r_p_tick     <= w_p_tick_next;
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_hsync      <= w_hsync_next;
      r_vsync      <= w_vsync_next;
      r_video_on   <= w_video_on_next;
      r_frame_tick <= w_frame_tick_next;
      r_run        <= w_run_next;
    end
  end

  assign vga.p_tick     = r_p_tick;
  assign vga.x          = r_x;
  assign vga.y          = r_y;
  assign vga.hsync      = r_hsync;
  assign vga.vsync      = r_vsync;
  assign vga.video_on   = r_video_on;
  assign vga.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync. u_dut0 uses the real 640x480 timing for the
// startup, line and mid-line reset scenarios; u_dut1 uses a shrunken
// timing (CLK_DIV=2, 15x11 total) so whole frames fit in a short run.
module tb_vga_sync;
  logic clk;
  logic reset0;
  logic reset1;

  int checks = 0;
  int passes = 0;
  int n0 = 0;
  int n1 = 0;
  int ft0 = 0;
  int ft1 = 0;

  vga_sync_if u_if0 ();
  vga_sync_if u_if1 ();

  vga_sync u_dut0 (.clk(clk), .reset(reset0), .vga(u_if0));

  vga_sync #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1)
  ) u_dut1 (.clk(clk), .reset(reset1), .vga(u_if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    n0++;
    n1++;
    if (u_if0.frame_tick) ft0++;
    if (u_if1.frame_tick) ft1++;
  endtask

  task automatic run_to0(input int target);
    while (n0 < target) tick();
  endtask

  task automatic run_to1(input int target);
    while (n1 < target) tick();
  endtask

  task automatic check_reset_state0(input string tag);
    checks++;
    if (u_if0.x !== 10'd0 || u_if0.y !== 10'd0) $display("FAIL %s xy: got x=%0d y=%0d want 0 0", tag, u_if0.x, u_if0.y);
    else passes++;
    checks++;
    if (u_if0.hsync !== 1'b1 || u_if0.vsync !== 1'b1) $display("FAIL %s sync: got h=%b v=%b want 1 1", tag, u_if0.hsync, u_if0.vsync);
    else passes++;
    checks++;
    if (u_if0.video_on !== 1'b0 || u_if0.p_tick !== 1'b0 || u_if0.frame_tick !== 1'b0)
      $display("FAIL %s flags: got vid=%b pt=%b ft=%b want 0 0 0", tag, u_if0.video_on, u_if0.p_tick, u_if0.frame_tick);
    else passes++;
  endtask

  // After release: p_tick high after edges 3,7,11; x steps at edges 4,8,12.
  task automatic check_startup0(input string tag);
    logic       exp_p;
    logic       exp_v;
    logic [9:0] exp_x;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_p = ((k % 4) == 3);
      exp_v = (k >= 3);
      exp_x = 10'(k / 4);
      checks++;
      if (u_if0.p_tick !== exp_p) $display("FAIL %s p_tick edge %0d: got %b want %b", tag, k, u_if0.p_tick, exp_p);
      else passes++;
      checks++;
      if (u_if0.x !== exp_x || u_if0.y !== 10'd0) $display("FAIL %s xy edge %0d: got %0d,%0d want %0d,0", tag, k, u_if0.x, u_if0.y, exp_x);
      else passes++;
      checks++;
      if (u_if0.video_on !== exp_v) $display("FAIL %s video_on edge %0d: got %b want %b", tag, k, u_if0.video_on, exp_v);
      else passes++;
    end
  endtask

  task automatic test_reset();
    #2;
    check_reset_state0("reset_hold");
    @(negedge clk);
    reset0 = 1'b0;
    n0 = 0;
    check_startup0("startup");
  endtask

  task automatic test_line();
    int low_clks;
    run_to0(4 * 656 - 1);
    checks++;
    if (u_if0.x !== 10'd655 || u_if0.hsync !== 1'b1) $display("FAIL pre_hsync: got x=%0d h=%b want 655 1", u_if0.x, u_if0.hsync);
    else passes++;
    tick();
    checks++;
    if (u_if0.x !== 10'd656 || u_if0.hsync !== 1'b0) $display("FAIL hsync_fall: got x=%0d h=%b want 656 0", u_if0.x, u_if0.hsync);
    else passes++;
    low_clks = 1;
    for (int g = 0; g < 1000 && u_if0.hsync === 1'b0; g++) begin
      tick();
      if (u_if0.hsync === 1'b0) low_clks++;
    end
    checks++;
    if (low_clks != 384) $display("FAIL hsync_width: got %0d clks want 384", low_clks);
    else passes++;
    checks++;
    if (u_if0.x !== 10'd752 || u_if0.hsync !== 1'b1) $display("FAIL hsync_rise: got x=%0d h=%b want 752 1", u_if0.x, u_if0.hsync);
    else passes++;
    run_to0(4 * 800 - 1);
    checks++;
    if (u_if0.x !== 10'd799 || u_if0.y !== 10'd0 || u_if0.p_tick !== 1'b1 || u_if0.video_on !== 1'b0)
      $display("FAIL line_end: got x=%0d y=%0d pt=%b vid=%b want 799 0 1 0", u_if0.x, u_if0.y, u_if0.p_tick, u_if0.video_on);
    else passes++;
    tick();
    checks++;
    if (u_if0.x !== 10'd0 || u_if0.y !== 10'd1 || u_if0.video_on !== 1'b1)
      $display("FAIL line_wrap: got x=%0d y=%0d vid=%b want 0 1 1", u_if0.x, u_if0.y, u_if0.video_on);
    else passes++;
    run_to0(4 * (800 + 640) - 1);
    checks++;
    if (u_if0.x !== 10'd639 || u_if0.video_on !== 1'b1) $display("FAIL vis_last: got x=%0d vid=%b want 639 1", u_if0.x, u_if0.video_on);
    else passes++;
    tick();
    checks++;
    if (u_if0.x !== 10'd640 || u_if0.video_on !== 1'b0) $display("FAIL blank_640: got x=%0d vid=%b want 640 0", u_if0.x, u_if0.video_on);
    else passes++;
    checks++;
    if (ft0 != 0) $display("FAIL no_frame_tick: got %0d pulses want 0", ft0);
    else passes++;
  endtask

  task automatic test_mid_reset_line();
    run_to0(4 * (800 + 700));
    checks++;
    if (u_if0.x !== 10'd700 || u_if0.y !== 10'd1 || u_if0.hsync !== 1'b0)
      $display("FAIL mid_hsync: got x=%0d y=%0d h=%b want 700 1 0", u_if0.x, u_if0.y, u_if0.hsync);
    else passes++;
    #2;
    reset0 = 1'b1;
    #1;
    check_reset_state0("async_reset");
    @(negedge clk);
    reset0 = 1'b0;
    n0 = 0;
    check_startup0("restart");
  endtask

  // Small timing: H_TOTAL=15 (hsync x 10..12, visible x<8),
  // V_TOTAL=11 (vsync y 8..9, visible y<6); frame = 330 clks.
  task automatic test_frame();
    int mx, my;
    int vid_cnt = 0, vs_cnt = 0, hs_cnt = 0, blank_row = 0, range_bad = 0, model_bad = 0;
    int first_ft = -1, second_ft = -1;
    logic [9:0] ft_x = 10'd0, ft_y = 10'd0;
    logic ft_p = 1'b0;
    logic ev, eh, evs;
    checks++;
    if (u_if1.x !== 10'd0 || u_if1.hsync !== 1'b1 || u_if1.vsync !== 1'b1 || u_if1.video_on !== 1'b0)
      $display("FAIL small_reset: got x=%0d h=%b v=%b vid=%b want 0 1 1 0", u_if1.x, u_if1.hsync, u_if1.vsync, u_if1.video_on);
    else passes++;
    @(negedge clk);
    reset1 = 1'b0;
    n1 = 0;
    ft1 = 0;
    for (int i = 0; i < 990; i++) begin
      tick();
      mx = (n1 / 2) % 15;
      my = (n1 / 30) % 11;
      ev = (mx < 8) && (my < 6);
      eh = !((mx >= 10) && (mx <= 12));
      evs = !((my >= 8) && (my <= 9));
      if (u_if1.x > 10'd14 || u_if1.y > 10'd10) range_bad++;
      if (u_if1.x !== 10'(mx) || u_if1.y !== 10'(my) || u_if1.video_on !== ev || u_if1.hsync !== eh ||
          u_if1.vsync !== evs || u_if1.p_tick !== ((n1 % 2) == 1)) model_bad++;
      if (n1 <= 330 && u_if1.p_tick === 1'b1) begin
        if (u_if1.video_on === 1'b1) vid_cnt++;
        if (u_if1.vsync === 1'b0) vs_cnt++;
        if (u_if1.hsync === 1'b0) hs_cnt++;
        if (my == 6 && u_if1.video_on === 1'b1) blank_row++;
      end
      if (u_if1.frame_tick === 1'b1) begin
        if (first_ft < 0) begin
          first_ft = n1; ft_x = u_if1.x; ft_y = u_if1.y; ft_p = u_if1.p_tick;
        end else if (second_ft < 0) begin
          second_ft = n1;
        end
      end
      if (n1 == 330) begin
        checks++;
        if (u_if1.x !== 10'd0 || u_if1.y !== 10'd0) $display("FAIL frame_wrap: got %0d,%0d want 0,0", u_if1.x, u_if1.y);
        else passes++;
      end
    end
    checks++;
    if (vid_cnt != 48) $display("FAIL video_count: got %0d want 48", vid_cnt); else passes++;
    checks++;
    if (vs_cnt != 30) $display("FAIL vsync_count: got %0d want 30", vs_cnt); else passes++;
    checks++;
    if (hs_cnt != 33) $display("FAIL hsync_count: got %0d want 33", hs_cnt); else passes++;
    checks++;
    if (blank_row != 0) $display("FAIL blank_row6: got %0d want 0", blank_row); else passes++;
    checks++;
    if (range_bad != 0) $display("FAIL counter_range: got %0d bad want 0", range_bad); else passes++;
    checks++;
    if (model_bad != 0) $display("FAIL timing_model: got %0d bad cycles want 0", model_bad); else passes++;
    checks++;
    if (ft1 != 3) $display("FAIL frame_tick_count: got %0d want 3", ft1); else passes++;
    checks++;
    if (first_ft != 329 || ft_x !== 10'd14 || ft_y !== 10'd10 || ft_p !== 1'b1)
      $display("FAIL frame_tick_pos: got n=%0d x=%0d y=%0d pt=%b want 329 14 10 1", first_ft, ft_x, ft_y, ft_p);
    else passes++;
    checks++;
    if (second_ft - first_ft != 330) $display("FAIL frame_period: got %0d want 330", second_ft - first_ft); else passes++;
  endtask

  task automatic test_mid_reset_frame();
    run_to1(990 + 2 * (9 * 15 + 11));
    checks++;
    if (u_if1.x !== 10'd11 || u_if1.y !== 10'd9 || u_if1.hsync !== 1'b0 || u_if1.vsync !== 1'b0)
      $display("FAIL mid_frame: got x=%0d y=%0d h=%b v=%b want 11 9 0 0", u_if1.x, u_if1.y, u_if1.hsync, u_if1.vsync);
    else passes++;
    #2;
    reset1 = 1'b1;
    #1;
    checks++;
    if (u_if1.x !== 10'd0 || u_if1.y !== 10'd0 || u_if1.hsync !== 1'b1 || u_if1.vsync !== 1'b1 ||
        u_if1.video_on !== 1'b0 || u_if1.p_tick !== 1'b0)
      $display("FAIL small_async_reset: got x=%0d y=%0d h=%b v=%b vid=%b pt=%b", u_if1.x, u_if1.y,
               u_if1.hsync, u_if1.vsync, u_if1.video_on, u_if1.p_tick);
    else passes++;
    @(negedge clk);
    reset1 = 1'b0;
    n1 = 0;
    tick();
    checks++;
    if (u_if1.p_tick !== 1'b1 || u_if1.video_on !== 1'b1 || u_if1.x !== 10'd0)
      $display("FAIL small_restart1: got pt=%b vid=%b x=%0d want 1 1 0", u_if1.p_tick, u_if1.video_on, u_if1.x);
    else passes++;
    tick();
    checks++;
    if (u_if1.p_tick !== 1'b0 || u_if1.x !== 10'd1) $display("FAIL small_restart2: got pt=%b x=%0d want 0 1", u_if1.p_tick, u_if1.x);
    else passes++;
  endtask

  initial begin
    reset0 = 1'b1;
    reset1 = 1'b1;
    test_reset();
    test_line();
    test_mid_reset_line();
    test_frame();
    test_mid_reset_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
